osc_tick_ctrl: RTL

//  Sequences the on-chip oscillator clock domain. Holds the fabric in warm-up for a

---
 rtl/osc_tick_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/osc_tick_ctrl.sv
// Oscillator tick controller: holds the fabric in warm-up for a fixed settle time,
// then emits a programmable one-cycle tick. Divisor reloads land on tick boundaries.
module osc_tick_ctrl #(
  parameter int unsigned STARTUP_CYCLES = 1024,
  parameter int unsigned DIV_W          = 16,
  parameter int unsigned DEFAULT_DIV    = 250,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_cfg_valid,
  input  logic [DIV_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_osc_ready,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_tick_cnt,
  output logic [DIV_W-1:0] o_cur_div
);

  localparam int unsigned WARM_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  localparam logic [0:0] ST_WARMUP = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  logic [0:0]       r_state,     w_state_d;
  logic [WARM_W-1:0] r_warm,     w_warm_d;
  logic [DIV_W-1:0] r_cnt,       w_cnt_d;
  logic [DIV_W-1:0] r_cur_div,   w_cur_div_d;
  logic             r_pend,      w_pend_d;
  logic [DIV_W-1:0] r_pend_div,  w_pend_div_d;
  logic             r_cfg_ready, w_cfg_ready_d;
  logic             r_osc_ready, w_osc_ready_d;
  logic             r_tick,      w_tick_d;
  logic [CNT_W-1:0] r_tick_cnt,  w_tick_cnt_d;

  logic [DIV_W-1:0] w_clamp;
  logic             w_last;
  logic             w_xfer;

  assign w_clamp = (i_cfg_div < DIV_W'(2)) ? DIV_W'(2) : i_cfg_div;
  assign w_last  = (r_cnt == r_cur_div - DIV_W'(1));
  assign w_xfer  = i_cfg_valid & r_cfg_ready;

  // Next-state logic for warm-up sequencing, divider and reload handshake
  always_comb begin
    w_state_d     = r_state;
    w_warm_d      = r_warm;
    w_cnt_d       = r_cnt;
    w_cur_div_d   = r_cur_div;
    w_pend_d      = r_pend;
    w_pend_div_d  = r_pend_div;
    w_cfg_ready_d = r_cfg_ready;
    w_osc_ready_d = r_osc_ready;
    w_tick_d      = 1'b0;
    w_tick_cnt_d  = r_tick_cnt;

    unique case (r_state)
      ST_WARMUP: begin
        w_cnt_d       = '0;
        w_cfg_ready_d = 1'b1;
        if (r_warm == WARM_W'(STARTUP_CYCLES - 1)) begin
          w_state_d     = ST_RUN;
          w_osc_ready_d = 1'b1;
        end else begin
          w_warm_d = r_warm + WARM_W'(1);
        end
        if (w_xfer) w_cur_div_d = w_clamp;
      end

      ST_RUN: begin
        if (i_enable) begin
          if (w_last) begin
            w_cnt_d      = '0;
            w_tick_d     = 1'b1;
            w_tick_cnt_d = r_tick_cnt + CNT_W'(1);
            // Pending divisor takes over exactly on the period boundary
            if (r_pend) begin
              w_cur_div_d = r_pend_div;
              w_pend_d    = 1'b0;
            end
          end else begin
            w_cnt_d = r_cnt + DIV_W'(1);
          end
          // Ready reopens one cycle after the applying tick, once pending has cleared
          if (!r_pend) w_cfg_ready_d = 1'b1;
          if (w_xfer) begin
            w_pend_d      = 1'b1;
            w_pend_div_d  = w_clamp;
            w_cfg_ready_d = 1'b0;
          end
        end else begin
          w_cnt_d       = '0;
          w_cfg_ready_d = 1'b1;
          if (r_pend) begin
            w_cur_div_d = r_pend_div;
            w_pend_d    = 1'b0;
          end else if (w_xfer) begin
            w_cur_div_d = w_clamp;
          end
        end
      end

      default: w_state_d = ST_WARMUP;
    endcase
  end

  // State registers; reset restarts warm-up and drops any pending reload
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_WARMUP;
      r_warm      <= '0;
      r_cnt       <= '0;
      r_cur_div   <= DIV_W'(DEFAULT_DIV);
      r_pend      <= 1'b0;
      r_pend_div  <= '0;
      r_cfg_ready <= 1'b1;
      r_osc_ready <= 1'b0;
      r_tick      <= 1'b0;
      r_tick_cnt  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_warm      <= w_warm_d;
      r_cnt       <= w_cnt_d;
      r_cur_div   <= w_cur_div_d;
      r_pend      <= w_pend_d;
      r_pend_div  <= w_pend_div_d;
      r_cfg_ready <= w_cfg_ready_d;
      r_osc_ready <= w_osc_ready_d;
      r_tick      <= w_tick_d;
      r_tick_cnt  <= w_tick_cnt_d;
    end
  end

  assign o_cfg_ready = r_cfg_ready;
  assign o_osc_ready = r_osc_ready;
  assign o_tick      = r_tick;
  assign o_tick_cnt  = r_tick_cnt;
  assign o_cur_div   = r_cur_div;

endmodule
